// File: rtl/counter_event_serializer.sv
// counter_event_serializer: merges multi-bit inc/dec event strobes and loads into
// single-step inc/dec/set commands for fast_counter, buffering excess in a saturating accumulator.
module counter_event_serializer #(
    parameter int N_INC      = 4,
    parameter int N_DEC      = 4,
    parameter int CNT_WIDTH  = 14,
    parameter int PEND_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [N_INC-1:0]             inc_in,
    input  logic [N_DEC-1:0]             dec_in,
    input  logic                         set_in,
    input  logic [CNT_WIDTH-1:0]         set_val_in,
    input  logic                         clr_ovf,
    output logic                         inc,
    output logic                         dec,
    output logic                         set,
    output logic [CNT_WIDTH-1:0]         set_val,
    output logic signed [PEND_WIDTH-1:0] pending,
    output logic                         busy,
    output logic                         overflow
);
    localparam int NMAX = (N_INC > N_DEC) ? N_INC : N_DEC;
    localparam int IW   = PEND_WIDTH + $clog2(NMAX + 1) + 1;
    localparam logic signed [IW-1:0] PMAX = {{(IW-PEND_WIDTH+1){1'b0}}, {(PEND_WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] PMIN = ~PMAX;
    logic signed [IW-1:0]         n_i, n_d, total, step;
    logic                         sat_hi, sat_lo;
    logic signed [PEND_WIDTH-1:0] pend_nxt;
    logic                         ovf_nxt;
    always_comb begin
        n_i = '0;
        n_d = '0;
        for (int i = 0; i < N_INC; i++) n_i = n_i + IW'(inc_in[i]);
        for (int i = 0; i < N_DEC; i++) n_d = n_d + IW'(dec_in[i]);
        total    = IW'(pending) + n_i - n_d;
        step     = (total > 0) ? total - 1 : (total < 0) ? total + 1 : '0;
        sat_hi   = step > PMAX;
        sat_lo   = step < PMIN;
        pend_nxt = set_in ? '0 : sat_hi ? PMAX[PEND_WIDTH-1:0] : sat_lo ? PMIN[PEND_WIDTH-1:0] : step[PEND_WIDTH-1:0];
        ovf_nxt  = (!set_in && (sat_hi || sat_lo)) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inc      <= 1'b0;
            dec      <= 1'b0;
            set      <= 1'b0;
            set_val  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            inc      <= !set_in && (total > 0);
            dec      <= !set_in && (total < 0);
            set      <= set_in;
            set_val  <= set_in ? set_val_in : set_val;
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end
    assign busy = pending != '0;
endmodule

// File: tb/tb_counter_event_serializer.sv
// tb_counter_event_serializer: checks default and PEND_WIDTH=4 instances against an
// integer reference model of the event-merging rules.
module tb_counter_event_serializer;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  inc_in = '0, dec_in = '0;
    logic        set_in = 1'b0, clr_ovf = 1'b0;
    logic [13:0] set_val_in = '0;
    logic        i8, d8, s8, b8, v8, i4, d4, s4, b4, v4;
    logic [13:0] sv8, sv4;
    logic [7:0]  p8;
    logic [3:0]  p4;
    logic [26:0] act [2];
    int          mp [2], mo [2], mi [2], md [2];
    int          ms, msv;
    int          wid [2] = '{8, 4};
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    counter_event_serializer u8 (
        .clk(clk), .nrst(nrst), .inc_in(inc_in), .dec_in(dec_in), .set_in(set_in),
        .set_val_in(set_val_in), .clr_ovf(clr_ovf), .inc(i8), .dec(d8), .set(s8),
        .set_val(sv8), .pending(p8), .busy(b8), .overflow(v8)
    );
    counter_event_serializer #(.PEND_WIDTH(4)) u4 (
        .clk(clk), .nrst(nrst), .inc_in(inc_in), .dec_in(dec_in), .set_in(set_in),
        .set_val_in(set_val_in), .clr_ovf(clr_ovf), .inc(i4), .dec(d4), .set(s4),
        .set_val(sv4), .pending(p4), .busy(b4), .overflow(v4)
    );

    assign act[0] = {i8, d8, s8, sv8, p8, b8, v8};
    assign act[1] = {i4, d4, s4, sv4, {{4{p4[3]}}, p4}, b4, v4};

    function automatic logic [26:0] exp_vec(int k);
        logic [7:0] p = 8'(mp[k]);
        return {mi[k][0], md[k][0], ms[0], 14'(msv), p, mp[k] != 0, mo[k][0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mp[k] = 0; mo[k] = 0; mi[k] = 0; md[k] = 0;
        end
        ms = 0; msv = 0;
    endtask

    task automatic tick();
        int t, s, hi, lo;
        for (int k = 0; k < 2; k++) begin
            t  = mp[k] + $countones(inc_in) - $countones(dec_in);
            hi = (1 << (wid[k] - 1)) - 1;
            lo = -(1 << (wid[k] - 1));
            if (set_in) begin
                mp[k] = 0; mi[k] = 0; md[k] = 0;
                if (clr_ovf) mo[k] = 0;
            end else begin
                mi[k] = int'(t > 0);
                md[k] = int'(t < 0);
                s = (t > 0) ? t - 1 : (t < 0) ? t + 1 : 0;
                if (s > hi) begin mp[k] = hi; mo[k] = 1; end
                else if (s < lo) begin mp[k] = lo; mo[k] = 1; end
                else begin mp[k] = s; if (clr_ovf) mo[k] = 0; end
            end
        end
        if (set_in) msv = int'(set_val_in);
        ms = int'(set_in);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ii, input logic [3:0] dd);
        inc_in = ii; dec_in = dd; set_in = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        drive(4'b1111, 4'b0000);
        tick();
        drive(4'b0000, 4'b0000);
        #3 nrst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (act[k] !== 27'd0) $display("FAIL reset_async dut%0d act=%h exp=%h", k, act[k], 27'd0);
            else passed++;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== 27'd0) $display("FAIL reset_hold dut%0d act=%h exp=%h", k, act[k], 27'd0);
                else passed++;
            end
        end
        #3 nrst = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(4'b0001, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            tick();
            drive(4'b0000, 4'b0000);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== exp_vec(k)) $display("FAIL single c%0d dut%0d act=%h exp=%h", c, k, act[k], exp_vec(k));
                else passed++;
            end
        end
    endtask

    task automatic test_burst();
        int pend_seen [4];
        drive(4'b1111, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            drive(4'b0000, 4'b0000);
            if (c < 4) pend_seen[c] = int'($signed(p8));
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== exp_vec(k)) $display("FAIL burst c%0d dut%0d act=%h exp=%h", c, k, act[k], exp_vec(k));
                else passed++;
            end
        end
        total++;
        if (pend_seen !== '{3, 2, 1, 0}) $display("FAIL burst_seq act=%0d,%0d,%0d,%0d exp=3,2,1,0", pend_seen[0], pend_seen[1], pend_seen[2], pend_seen[3]);
        else passed++;
        drive(4'b0011, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            drive(4'b0000, 4'b0000);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== exp_vec(k)) $display("FAIL cancel c%0d dut%0d act=%h exp=%h", c, k, act[k], exp_vec(k));
                else passed++;
            end
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        drive(4'b1111, 4'b0000);
        for (int c = 0; c < 14; c++) begin
            if (c == 3) drive(4'b0000, 4'b0000);
            tick();
            pulses += int'(i4);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== exp_vec(k)) $display("FAIL saturate c%0d dut%0d act=%h exp=%h", c, k, act[k], exp_vec(k));
                else passed++;
            end
        end
        total++;
        if (pulses !== 10) $display("FAIL sat_pulses act=%0d exp=10", pulses);
        else passed++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++;
        if ({v4, v8} !== 2'b00) $display("FAIL clr_ovf act=%b exp=00", {v4, v8});
        else passed++;
    endtask

    task automatic test_set_priority();
        drive(4'b1111, 4'b0000); tick();
        tick();
        drive(4'b0000, 4'b0000); tick();
        total++;
        if ($signed(p8) !== 8'sd5) $display("FAIL set_prep act=%0d exp=5", $signed(p8));
        else passed++;
        drive(4'b1111, 4'b0000);
        set_in = 1'b1; set_val_in = 14'h1A5;
        tick();
        set_in = 1'b0; drive(4'b0000, 4'b0000);
        total++;
        if ({s8, sv8, i8, p8, b8} !== {1'b1, 14'h1A5, 1'b0, 8'd0, 1'b0})
            $display("FAIL set_cmd act=%b/%h/%b/%0d/%b exp=1/1a5/0/0/0", s8, sv8, i8, p8, b8);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== exp_vec(k)) $display("FAIL set_after c%0d dut%0d act=%h exp=%h", c, k, act[k], exp_vec(k));
                else passed++;
            end
        end
    endtask

    task automatic test_reset_drain();
        drive(4'b0000, 4'b1111); tick();
        tick();
        drive(4'b0000, 4'b0000);
        total++;
        if ($signed(p8) !== -8'sd6 || d8 !== 1'b1) $display("FAIL drain_prep act=%0d/%b exp=-6/1", $signed(p8), d8);
        else passed++;
        #3 nrst = 1'b0;
        #1;
        total++;
        if ({p8, d8, p4, d4} !== '0) $display("FAIL drain_reset act=%h/%b/%h/%b exp=0", p8, d8, p4, d4);
        else passed++;
        #3 nrst = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if ({d8, d4, b8, b4} !== 4'b0) $display("FAIL drain_after c%0d act=%b exp=0000", c, {d8, d4, b8, b4});
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            inc_in     = 4'($urandom);
            dec_in     = 4'($urandom);
            set_in     = ($urandom_range(0, 15) == 0);
            set_val_in = 14'($urandom);
            clr_ovf    = !set_in && ($urandom_range(0, 7) == 0);
            if (c % 50 < 10) dec_in = '0;
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act[k] !== exp_vec(k)) $display("FAIL random c%0d dut%0d act=%h exp=%h", c, k, act[k], exp_vec(k));
                else passed++;
            end
        end
        drive(4'b0000, 4'b0000);
    endtask

    initial begin
        model_reset();
        #12 nrst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_burst();
        test_saturate();
        test_set_priority();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
